uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver: 8N1 format, LSB first, fixed baud rate derived from the system clock. It recovers bytes from the `rxd` pin and presents each one as a single-cycle strobe to the core logic. It is the receive-side partner of the team's UART transmitter and shares its line conventions: idle high, one start bit low, 8 data bits, one stop bit high.

## Interface
- `CLK_HZ`, default 200_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate. `DIV = CLK_HZ/BAUD` must satisfy 4 ≤ DIV ≤ 65535; this is checked by an elaboration assertion.
- `clk` input, 1 bit: system clock; all logic is on the rising edge.
- `nrst` input, 1 bit: reset, synchronous, active-low.
- `rxd` input, 1 bit: asynchronous serial line, idle high.
- `rx_data` output, 8 bits: last received byte, held until the next frame completes.
- `rx_valid` output, 1 bit: one-cycle strobe when `rx_data` holds a frame with a good stop bit.
- `rx_frame_err` output, 1 bit: one-cycle strobe when the stop bit sampled low.
- `rx_busy` output, 1 bit: high while a frame is being received.

## Operation
- **Input synchronizer:** `rxd` passes through a 2-FF synchronizer (reset value 1) to give `rxd_s`. A third register holds `rxd_s` delayed by one cycle, for falling-edge detection.
- **Bit counter:** a 16-bit down-counter `cntr`. A sample point is the cycle where `cntr==0`; the counter then reloads DIV-1.
- **State machine states:** IDLE, START, DATA, STOP.
- **IDLE:** a falling edge on `rxd_s` (previous 1, current 0) loads `cntr <= DIV/2 - 1` (integer division) and moves to START. `rx_busy` goes high in that same cycle.
- **START:** at the sample point, a low sample moves to DATA with bit index 0. A high sample is a glitch: return to IDLE with no strobe.
- **DATA:** at each sample point the bit is shifted into bit 7 of the shift register (right shift, so LSB lands first). After the 8th bit, move to STOP.
- **STOP:** at the sample point, update `rx_data` from the shift register and return to IDLE. A high sample pulses `rx_valid`; a low sample pulses `rx_frame_err`. The two strobes are never high together.
- **Re-arm:** IDLE requires a fresh 1→0 edge, so a held-low line (break) after a frame error produces no further frames until it returns high.
- **Back-to-back frames:** the return to IDLE happens at mid-stop-bit, so a start edge arriving half a bit later is captured.
- **Reset:** `nrst` low in any state forces IDLE, discards the partial frame and emits no strobe.
- **Reset values:** `rx_data` = 0x00, `rx_valid` = 0, `rx_frame_err` = 0, `rx_busy` = 0, synchronizer = 1, `cntr` = 0.

## Timing
- Strobes are registered and assert in the cycle after the stop sample point, for exactly one cycle. `rx_busy` falls in the same cycle.
- **Latency:** the falling edge is detected 3 cycles after the `rxd` pin falls (two synchronizer stages plus the edge register). The strobe follows DIV/2 + 9·DIV cycles after detection.
- There is no backpressure. The consumer must take `rx_data` within one frame time, after which the next frame overwrites it.

## Configuration
- **`UART_RX_MAJORITY_EN` defined:** each bit value is the 2-of-3 majority of `rxd_s` at `cntr==2`, `1` and `0`. This applies to the start, data and stop bits; the decision is made at `cntr==0`, so latency is unchanged.
- **`UART_RX_MAJORITY_EN` undefined:** a single sample of `rxd_s` is taken at `cntr==0`, and the vote registers are not built.

## Structure
- **Package `uart_pkg`:** the `uart_rx_state_t` enum (IDLE/START/DATA/STOP), the frame constants (`UART_DATA_BITS` = 8), and the divisor function `uart_div(clk_hz, baud)`. The transmitter also uses `uart_div`.
- **Sub-module `sync_2ff`:** a generic 1-bit two-stage synchronizer with reset value as a parameter, instantiated once here.

## Test plan
Use CLK_HZ=16, BAUD=1 (DIV=16) throughout, so one bit time is 16 cycles.
- **Single byte:** drive 0xA5 as 8N1 at 16 cycles per bit. Expect `rx_valid` for 1 cycle with `rx_data`=0xA5 at 3+8+144 cycles after the `rxd` fall. `rx_frame_err` stays 0.
- **Back-to-back frames:** send 0x00, 0xFF, 0x55 with no idle gap. Expect three `rx_valid` pulses exactly 160 cycles apart, carrying the correct data.
- **Framing error:** send 0x3C with the stop bit held low and the line kept low for 40 more cycles. Expect `rx_frame_err` for 1 cycle, `rx_data`=0x3C, no `rx_valid`, and no further strobes until `rxd` rises and falls again.
- **Glitch rejection:** pulse `rxd` low for 4 cycles from idle. Expect `rx_busy` high for 8 cycles, then IDLE with no strobe.
- **Reset mid-frame:** assert `nrst` for 1 cycle during data bit 4. Expect all outputs at reset values with no strobe; a following clean 0x81 frame is then received correctly.
- **Majority vote (with `UART_RX_MAJORITY_EN`):** send 0xF0 with a 1-cycle inverted spike at `cntr==1` of every bit. Expect `rx_data`=0xF0 with `rx_valid`. Without the macro, a spike at `cntr==0` on every data bit yields 0x0F.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver (and the transmitter).
//   uart_rx_state_t : receiver FSM states (IDLE/START/DATA/STOP)
//   UART_DATA_BITS  : data bits per frame (8N1)
//   uart_div()      : system clocks per bit for a given clock and baud rate
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  localparam int UART_DATA_BITS = 8;

  function automatic int uart_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-stage synchronizer for an asynchronous input.
//   clk     : destination clock
//   nrst    : synchronous active-low reset, both stages load RST_VAL
//   d       : asynchronous input
//   q       : synchronized output (two clk cycles of latency)
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, fixed divisor DIV = CLK_HZ/BAUD.
//   clk          : system clock, rising edge
//   nrst         : synchronous active-low reset
//   rxd          : asynchronous serial line, idle high
//   rx_data      : last completed frame, held until the next one completes
//   rx_valid     : one-cycle strobe, frame with good stop bit
//   rx_frame_err : one-cycle strobe, stop bit sampled low
//   rx_busy      : high while a frame is in progress
// Output protocol: no backpressure. rx_valid/rx_frame_err are mutually
// exclusive single-cycle strobes qualifying rx_data in that same cycle; the
// consumer must take rx_data before the next frame completes.
// Build option: define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3
// vote of the samples at cntr==2,1,0 instead of the single cntr==0 sample.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 200_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int          DIV    = uart_div(CLK_HZ, BAUD);
  localparam logic [15:0] RELOAD = 16'(DIV - 1);
  localparam logic [15:0] HALF   = 16'(DIV / 2 - 1);
  localparam logic [2:0]  LAST_BIT = 3'(UART_DATA_BITS - 1);

  if (DIV < 4 || DIV > 65535) begin : g_bad_div
    $error("uart_rx: CLK_HZ/BAUD must lie in 4..65535");
  end

  uart_rx_state_t state_q, state_d;
  logic [15:0]    cntr_q, cntr_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shreg_q, shreg_d;
  logic [7:0]     data_d;
  logic           valid_d, err_d;
  logic           rxd_s, rxd_d;
  logic           sample_pt;
  logic           bit_val;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (rxd),
    .q    (rxd_s)
  );

  // Previous synchronized value, for 1->0 edge detection in IDLE.
  always_ff @(posedge clk) begin
    if (!nrst) rxd_d <= 1'b1;
    else       rxd_d <= rxd_s;
  end

  assign sample_pt = (cntr_q == 16'd0);

`ifdef UART_RX_MAJORITY_EN
  // Early samples two and one cycles before the decision point.
  logic vote2_q, vote1_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      vote2_q <= 1'b1;
      vote1_q <= 1'b1;
    end else begin
      if (cntr_q == 16'd2) vote2_q <= rxd_s;
      if (cntr_q == 16'd1) vote1_q <= rxd_s;
    end
  end

  assign bit_val = (vote2_q & vote1_q) | (vote2_q & rxd_s) | (vote1_q & rxd_s);
`else
  assign bit_val = rxd_s;
`endif

  always_comb begin
    state_d   = state_q;
    cntr_d    = 16'd0;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    data_d    = rx_data;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    if (state_q != IDLE) cntr_d = sample_pt ? RELOAD : cntr_q - 16'd1;

    case (state_q)
      IDLE: begin
        // First sample lands half a bit in, i.e. mid start bit.
        if (rxd_d && !rxd_s) begin
          cntr_d  = HALF;
          state_d = START;
        end
      end
      START: begin
        if (sample_pt) begin
          if (!bit_val) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (sample_pt) begin
          shreg_d = {bit_val, shreg_q[7:1]};
          if (bit_idx_q == LAST_BIT) state_d   = STOP;
          else                       bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit leaves half a bit to catch the next start edge.
        if (sample_pt) begin
          data_d  = shreg_q;
          valid_d = bit_val;
          err_d   = !bit_val;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= IDLE;
      cntr_q       <= 16'd0;
      bit_idx_q    <= 3'd0;
      shreg_q      <= 8'h00;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      cntr_q       <= cntr_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      rx_data      <= data_d;
      rx_valid     <= valid_d;
      rx_frame_err <= err_d;
    end
  end

  assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLK_HZ=16, BAUD=1 (16 cycles per bit).
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Scoreboard: {is_frame_err, data} and the cycle the strobe must appear in.
  logic [8:0] exp_q[$];
  int         exp_t_q[$];

  logic [8:0] mon_e;
  int         mon_t;

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  uart_rx #(.CLK_HZ(16), .BAUD(1)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .rxd          (rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  // scoreboard monitor
  always @(negedge clk) begin
    if (rx_valid || rx_frame_err) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_strobe: valid=%0b err=%0b data=%02h cycle=%0d, required no strobe",
                 rx_valid, rx_frame_err, rx_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = exp_t_q.pop_front();
        total++;
        if (rx_data !== mon_e[7:0]) begin
          bad++;
          $display("FAIL strobe_data: got %02h, required %02h", rx_data, mon_e[7:0]);
        end
        total++;
        if (rx_valid !== !mon_e[8] || rx_frame_err !== mon_e[8]) begin
          bad++;
          $display("FAIL strobe_kind: valid=%0b err=%0b, required valid=%0b err=%0b",
                   rx_valid, rx_frame_err, !mon_e[8], mon_e[8]);
        end
        total++;
        if (cyc !== mon_t) begin
          bad++;
          $display("FAIL strobe_latency: cycle %0d, required %0d", cyc, mon_t);
        end
      end
    end
  end

  // driver tasks
  task automatic drive_level(input logic b, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rxd = b;
    end
  endtask

  // Sends one frame; spike_mask[j] inverts bit j (0=start, 9=stop) for the
  // single cycle at offset spike_off within the bit.
  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input int spike_off, input logic [9:0] spike_mask,
                            input logic [7:0] exp_data);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    for (int j = 0; j < 10; j++) begin
      for (int c = 0; c < 16; c++) begin
        @(posedge clk); #1;
        rxd = (spike_mask[j] && c == spike_off) ? ~bits[j] : bits[j];
        if (j == 0 && c == 0) begin
          exp_q.push_back({~stop, exp_data});
          exp_t_q.push_back(cyc + 155);
        end
      end
    end
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drained: %0d strobes pending, required 0", name, exp_q.size());
      exp_q.delete();
      exp_t_q.delete();
    end
  endtask

  // tests
  task automatic test_reset();
    nrst = 1'b0;
    rxd  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %02h, required 00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b, required 0", rx_valid); end
    total++; if (rx_frame_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b, required 0", rx_frame_err); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b, required 0", rx_busy); end
    nrst = 1'b1;
    drive_level(1'b1, 10);
  endtask

  task automatic test_single_byte();
    send_frame(8'hA5, 1'b1, -1, 10'b0, 8'hA5);
    drive_level(1'b1, 10);
    check_drained("single");
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL single_hold: got %02h, required a5", rx_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat [3];
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h55;
    for (int i = 0; i < 3; i++) send_frame(pat[i], 1'b1, -1, 10'b0, pat[i]);
    drive_level(1'b1, 10);
    check_drained("b2b");
    total++; if (rx_data !== 8'h55) begin bad++; $display("FAIL b2b_hold: got %02h, required 55", rx_data); end
  endtask

  task automatic test_frame_error();
    int busy_n;
    send_frame(8'h3C, 1'b0, -1, 10'b0, 8'h3C);
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rx_busy) busy_n++;
    end
    total++; if (busy_n !== 0) begin bad++; $display("FAIL break_busy: %0d busy cycles, required 0", busy_n); end
    drive_level(1'b1, 40);
    check_drained("ferr");
    total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL ferr_data: got %02h, required 3c", rx_data); end
  endtask

  task automatic test_glitch();
    int busy_n;
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rx_busy) busy_n++;
      rxd = (i < 4) ? 1'b0 : 1'b1;
    end
    total++; if (busy_n !== 8) begin bad++; $display("FAIL glitch_busy: %0d busy cycles, required 8", busy_n); end
    check_drained("glitch");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'hC3;
    drive_level(1'b0, 16);
    for (int j = 0; j < 4; j++) drive_level(d[j], 16);
    drive_level(d[4], 8);
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL midframe_busy: got %0b, required 1", rx_busy); end
    @(posedge clk); #1;
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    rxd  = 1'b1;
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_mid_data: got %02h, required 00", rx_data); end
    total++; if (rx_valid !== 1'b0 || rx_frame_err !== 1'b0) begin
      bad++; $display("FAIL rst_mid_strobe: valid=%0b err=%0b, required 0 0", rx_valid, rx_frame_err);
    end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %0b, required 0", rx_busy); end
    drive_level(1'b1, 20);
    send_frame(8'h81, 1'b1, -1, 10'b0, 8'h81);
    drive_level(1'b1, 10);
    check_drained("rst_mid");
    total++; if (rx_data !== 8'h81) begin bad++; $display("FAIL rst_mid_after: got %02h, required 81", rx_data); end
  endtask

  task automatic test_sampling_point();
`ifdef UART_RX_MAJORITY_EN
    // Single-cycle spike at cntr==1 of every bit is outvoted.
    send_frame(8'hF0, 1'b1, 7, 10'h3FF, 8'hF0);
`else
    // Single-cycle spike exactly at cntr==0 of every data bit inverts it.
    send_frame(8'hF0, 1'b1, 8, 10'b01_1111_1110, 8'h0F);
`endif
    drive_level(1'b1, 10);
    check_drained("sample");
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    test_sampling_point();
    drive_level(1'b1, 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
